aes_encryption: RTL and testbench
=================================

AES_ENCRYPTION -- requirements
Module: aes_encryption

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 n_rst  in  1  asynchronous active-low reset.
REQ-004 fifo_in  in  128  plaintext block; byte 0 in [127:120]; column-major state order per FIPS-197.
REQ-005 fifo_empty  in  1  input FIFO has no block.
REQ-006 read_fifo  out  1  pop strobe; fifo_in is captured in the same cycle.
REQ-007 round_key_input  in  128  round key returned combinationally for round_key_addr.
REQ-008 round_key_addr  out  4  round-key index, 0..10.
REQ-009 out_full  in  1  downstream cannot accept a block.
REQ-010 data_output  out  128  ciphertext block, registered.
REQ-011 data_valid  out  1  data_output holds an unconsumed ciphertext.
REQ-012 busy  out  1  a block is in flight (ROUND state).

Function
REQ-013 The block SHALL be an iterative AES-128 encryptor executing one round per clock, using an FSM with states IDLE, ROUND and DONE.
REQ-014 Registers: state block (128), round counter (4), result (128), FSM state.
REQ-015 round_key_addr SHALL be 0 in IDLE and DONE, and equal to the round counter (1..10) in ROUND.
REQ-016 IDLE: when fifo_empty=0, read_fifo=1 for exactly that cycle; next state block = fifo_in XOR round_key_input (key 0); counter <= 1; go to ROUND.
REQ-017 ROUND, counter 1..9: state block <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state block))), round_key_input); counter increments.
REQ-018 ROUND, counter 10: result <= AddRoundKey(ShiftRows(SubBytes(state block))), with no MixColumns; go to DONE; data_valid=1 from the next cycle.
REQ-019 Latency: the pop edge in cycle T SHALL give data_valid=1 in cycle T+11.
REQ-020 A block is consumed on any rising edge with data_valid=1 and out_full=0.
REQ-021 DONE with out_full=1: data_output and data_valid SHALL hold unchanged, and read_fifo=0.
REQ-022 DONE with out_full=0 and fifo_empty=1: result is consumed; go to IDLE; data_valid=0 next cycle.
REQ-023 DONE with out_full=0 and fifo_empty=0: consume and pop in the same cycle (read_fifo=1, key 0 XOR load, counter <= 1, go to ROUND); data_valid=0 next cycle.
REQ-024 read_fifo SHALL never assert in ROUND, and never assert when fifo_empty=1.
REQ-025 data_output SHALL change only at the REQ-018 capture edge; between blocks it retains the last ciphertext.
REQ-026 SubBytes SHALL use the forward FIPS-197 S-box; MixColumns SHALL use the forward GF(2^8) matrix [02 03 01 01] with reduction polynomial 0x11B.
REQ-027 busy SHALL be 1 exactly in ROUND.
REQ-028 fifo_in is ignored in every cycle where read_fifo=0.

Reset
REQ-029 n_rst=0 SHALL immediately force FSM=IDLE, counter=0, state block=0, result=0, data_valid=0, busy=0, read_fifo=0 and round_key_addr=0.
REQ-030 Reset mid-ROUND or mid-DONE SHALL abandon the block; no output appears for it after reset is released.
REQ-031 The first pop after reset SHALL occur no earlier than the first rising edge with n_rst=1 and fifo_empty=0.

Verification
REQ-032 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> data_output 69c4e0d86a7b0430d8cdb78070b4c55a; data_valid rises 11 cycles after the pop.
REQ-033 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; round_key_addr sequence 0,1..10,0.
REQ-034 Backpressure: out_full=1 for 5 cycles after data_valid rises -> output stable, read_fifo=0; on release, consumed in one cycle.
REQ-035 Back-to-back: two blocks queued, out_full=0 -> second pop in the consume cycle of the first; second ciphertext valid 11 cycles later; both correct.
REQ-036 Reset asserted at round 5, with the FIFO holding the next block -> all outputs 0 at once; after release the queued block encrypts correctly and no stale output appears.
REQ-037 fifo_empty=1 held for 20 cycles after reset -> read_fifo, busy and data_valid stay 0.

Source files
------------

// File: rtl/aes_encryption.sv
// Iterative AES-128 encryptor: one round per clock, round keys fetched from an
// external key store by index, one ciphertext buffered until downstream accepts it.
module aes_encryption (
   input  logic         clk,
   input  logic         n_rst,
   input  logic [127:0] fifo_in,
   input  logic         fifo_empty,
   output logic         read_fifo,
   input  logic [127:0] round_key_input,
   output logic [3:0]   round_key_addr,
   input  logic         out_full,
   output logic [127:0] data_output,
   output logic         data_valid,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   localparam logic [3:0] LAST_ROUND = 4'd10;

   // Forward S-box, entry 0 in the leftmost byte.
   localparam logic [255:0][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   fsm_t         state;
   logic [3:0]   round_cnt;
   logic [127:0] state_blk;
   logic [127:0] result;
   logic [127:0] sr_blk;
   logic [127:0] mc_blk;
   logic         pop;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[8'd255 - b];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // SubBytes and ShiftRows fused: output (row, col) takes input (row, col + row).
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127 - 8*(4*c + row) -: 8] = sbox(s[127 - 8*(4*((c + row) % 4) + row) -: 8]);
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = s[127 - 32*c -: 32];
         r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return r;
   endfunction

   // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
   always_comb begin
      sr_blk = sub_shift(state_blk);
      mc_blk = mix_columns(sr_blk);
   end

   // Pop is gated by n_rst so no strobe leaks out while reset is held.
   assign pop = n_rst & ~fifo_empty &
                ((state == IDLE) | ((state == DONE) & ~out_full));

   assign read_fifo      = pop;
   assign round_key_addr = (state == ROUND) ? round_cnt : 4'd0;
   assign busy           = (state == ROUND);
   assign data_valid     = (state == DONE);
   assign data_output    = result;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         round_cnt <= '0;
         state_blk <= '0;
         result    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  state_blk <= fifo_in ^ round_key_input;
                  round_cnt <= 4'd1;
                  state     <= ROUND;
               end
            end
            ROUND: begin
               if (round_cnt == LAST_ROUND) begin
                  result    <= sr_blk ^ round_key_input;
                  round_cnt <= '0;
                  state     <= DONE;
               end else begin
                  state_blk <= mc_blk ^ round_key_input;
                  round_cnt <= round_cnt + 4'd1;
               end
            end
            DONE: begin
               // Consume and reload in one edge keeps back-to-back blocks gap-free.
               if (pop) begin
                  state_blk <= fifo_in ^ round_key_input;
                  round_cnt <= 4'd1;
                  state     <= ROUND;
               end else if (!out_full) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_encryption.sv
// Bench for aes_encryption: FIFO and key-store models, a byte-level AES-128
// reference with a computed S-box, and a cycle-accurate output scoreboard.
module tb_aes_encryption;

   logic         clk;
   logic         n_rst;
   logic [127:0] fifo_in;
   logic         fifo_empty;
   logic         read_fifo;
   logic [127:0] round_key_input;
   logic [3:0]   round_key_addr;
   logic         out_full;
   logic [127:0] data_output;
   logic         data_valid;
   logic         busy;

   typedef struct {
      logic [127:0] ct;
      int           due;
   } exp_t;

   logic [127:0] rk [16];
   logic [7:0]   sb [256];
   logic [127:0] fifo_q [$];
   exp_t         exp_q [$];
   int           pop_log [$];
   logic [3:0]   addr_log [$];
   int           cyc;
   int           total;
   int           bad;
   bit           dv_seen;
   logic         prev_dv;
   logic [127:0] prev_do;

   assign round_key_input = rk[round_key_addr];

   aes_encryption dut (
      .clk             (clk),
      .n_rst           (n_rst),
      .fifo_in         (fifo_in),
      .fifo_empty      (fifo_empty),
      .read_fifo       (read_fifo),
      .round_key_input (round_key_input),
      .round_key_addr  (round_key_addr),
      .out_full        (out_full),
      .data_output     (data_output),
      .data_valid      (data_valid),
      .busy            (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int i = 0; i < 256; i++) begin
         inv   = ginv(8'(i));
         sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic set_key(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h000000};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] key;
      logic [127:0] ct;
      key = rk[0];
      for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[row + 4*c] = s[row + 4*((c + row) % 4)];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               s[4*c + row] = (r < 10) ?
                  (gmul(t[4*c + row], 8'h02) ^ gmul(t[4*c + (row+1)%4], 8'h03) ^
                   t[4*c + (row+2)%4] ^ t[4*c + (row+3)%4]) : t[4*c + row];
         key = rk[r];
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ key[127 - 8*i -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
      return ct;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- FIFO model and per-cycle scoreboard ----------------
   task automatic update_fifo();
      fifo_empty = (fifo_q.size() == 0);
      fifo_in    = fifo_empty ? rand128() : fifo_q[0];
   endtask

   task automatic push(input logic [127:0] pt);
      fifo_q.push_back(pt);
      update_fifo();
   endtask

   task automatic tick();
      bit   pop_now;
      exp_t e;
      pop_now = 0;
      @(negedge clk);
      addr_log.push_back(round_key_addr);
      if (read_fifo === 1'b1) begin
         total++;
         if (n_rst !== 1'b1 || fifo_empty !== 1'b0 || busy !== 1'b0 ||
             (data_valid === 1'b1 && out_full === 1'b1)) begin
            bad++;
            $display("FAIL read_fifo_illegal cyc=%0d n_rst=%b fifo_empty=%b busy=%b data_valid=%b out_full=%b",
                     cyc, n_rst, fifo_empty, busy, data_valid, out_full);
         end else begin
            e.ct  = aes_ref(fifo_q[0]);
            e.due = cyc + 11;
            exp_q.push_back(e);
            pop_log.push_back(cyc);
            pop_now = 1;
         end
      end
      total++;
      if (busy === 1'b1 && data_valid === 1'b1) begin
         bad++;
         $display("FAIL busy_and_valid cyc=%0d got busy=%b data_valid=%b want not both", cyc, busy, data_valid);
      end
      if (data_output !== prev_do) begin
         total++;
         if (!(data_valid === 1'b1 && prev_dv === 1'b0)) begin
            bad++;
            $display("FAIL data_output_changed cyc=%0d got %h want held %h", cyc, data_output, prev_do);
         end
      end
      if (data_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid cyc=%0d data_output=%h want data_valid=0", cyc, data_output);
         end else begin
            if (!dv_seen) begin
               dv_seen = 1;
               total++;
               if (cyc !== exp_q[0].due) begin
                  bad++;
                  $display("FAIL latency got valid at cyc=%0d want cyc=%0d", cyc, exp_q[0].due);
               end
            end
            if (out_full === 1'b0) begin
               total++;
               if (data_output !== exp_q[0].ct) begin
                  bad++;
                  $display("FAIL ciphertext cyc=%0d got %h want %h", cyc, data_output, exp_q[0].ct);
               end
               exp_q.delete(0);
               dv_seen = 0;
            end
         end
      end
      prev_dv = data_valid;
      prev_do = data_output;
      @(posedge clk);
      #1;
      cyc++;
      if (pop_now) fifo_q.delete(0);
      update_fifo();
   endtask

   task automatic apply_reset(input int hold);
      n_rst = 1'b0;
      #1;
      total += 5;
      if (read_fifo !== 1'b0) begin bad++; $display("FAIL reset_read_fifo got %b want 0", read_fifo); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
      if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
      if (round_key_addr !== 4'd0) begin bad++; $display("FAIL reset_key_addr got %0d want 0", round_key_addr); end
      if (data_output !== '0) begin bad++; $display("FAIL reset_data_output got %h want 0", data_output); end
      exp_q.delete();
      dv_seen = 0;
      prev_dv = 1'b0;
      prev_do = '0;
      repeat (hold) tick();
      n_rst = 1'b1;
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int n;
      n = 0;
      while (data_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (data_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s_valid_timeout got data_valid=%b after %0d cycles want 1", tag, data_valid, budget);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      out_full = 1'b0;
      while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      total++;
      if (fifo_q.size() != 0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout got fifo=%0d pending=%0d want 0 0", fifo_q.size(), exp_q.size());
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset(3);
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if (read_fifo !== 1'b0 || busy !== 1'b0 || data_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_empty cyc=%0d got read_fifo=%b busy=%b data_valid=%b want 0 0 0",
                     cyc, read_fifo, busy, data_valid);
         end
      end
   endtask

   task automatic test_fips_c1();
      set_key(128'h000102030405060708090a0b0c0d0e0f);
      pop_log.delete();
      push(128'h00112233445566778899aabbccddeeff);
      wait_valid(20, "c1");
      total += 2;
      if (data_output !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
         bad++;
         $display("FAIL c1_ciphertext got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", data_output);
      end
      if (pop_log.size() != 1 || cyc - pop_log[0] != 11) begin
         bad++;
         $display("FAIL c1_latency got pops=%0d cycles=%0d want 1 11", pop_log.size(), cyc - pop_log[0]);
      end
      drain(40);
   endtask

   task automatic test_fips_b();
      int want;
      set_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
      addr_log.delete();
      push(128'h3243f6a8885a308d313198a2e0370734);
      wait_valid(20, "appb");
      total++;
      if (data_output !== 128'h3925841d02dc09fbdc118597196a0b32) begin
         bad++;
         $display("FAIL appb_ciphertext got %h want 3925841d02dc09fbdc118597196a0b32", data_output);
      end
      tick();
      for (int i = 0; i < 12; i++) begin
         want = (i == 0 || i == 11) ? 0 : i;
         total++;
         if (i >= addr_log.size() || addr_log[i] !== 4'(want)) begin
            bad++;
            $display("FAIL key_addr_seq step=%0d got %0d want %0d", i,
                     (i < addr_log.size()) ? int'(addr_log[i]) : -1, want);
         end
      end
      drain(40);
   endtask

   task automatic test_backpressure();
      logic [127:0] a;
      logic [127:0] a_ct;
      set_key(rand128());
      a    = rand128();
      a_ct = aes_ref(a);
      push(a);
      push(rand128());
      wait_valid(20, "bp");
      out_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (data_valid !== 1'b1 || data_output !== a_ct || read_fifo !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_hold cyc=%0d got valid=%b read=%b out=%h want 1 0 %h",
                     cyc, data_valid, read_fifo, data_output, a_ct);
         end
      end
      out_full = 1'b0;
      tick();
      total++;
      if (data_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL backpressure_release got data_valid=%b busy=%b want 0 1", data_valid, busy);
      end
      drain(40);
   endtask

   task automatic test_back_to_back();
      set_key(rand128());
      pop_log.delete();
      push(rand128());
      push(rand128());
      drain(60);
      total++;
      if (pop_log.size() != 2 || pop_log[1] - pop_log[0] != 11) begin
         bad++;
         $display("FAIL back_to_back_pop got pops=%0d gap=%0d want 2 11", pop_log.size(), pop_log[1] - pop_log[0]);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      set_key(rand128());
      push(rand128());
      push(rand128());
      n = 0;
      while (round_key_addr !== 4'd5 && n < 20) begin
         tick();
         n++;
      end
      total++;
      if (round_key_addr !== 4'd5 || busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset_reach got addr=%0d busy=%b want 5 1", round_key_addr, busy);
      end
      pop_log.delete();
      apply_reset(2);
      drain(60);
      total++;
      if (pop_log.size() != 1) begin
         bad++;
         $display("FAIL mid_reset_requeue got pops=%0d want 1", pop_log.size());
      end
   endtask

   task automatic test_random();
      int n;
      int pushed;
      for (int k = 0; k < 3; k++) begin
         set_key(rand128());
         pushed = 0;
         n = 0;
         while ((pushed < 8 || fifo_q.size() != 0 || exp_q.size() != 0) && n < 800) begin
            if (pushed < 8 && $urandom_range(0, 2) == 0) begin
               push(rand128());
               pushed++;
            end
            out_full = ($urandom_range(0, 3) == 0);
            tick();
            n++;
         end
         drain(60);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      cyc      = 0;
      dv_seen  = 0;
      prev_dv  = 1'b0;
      prev_do  = '0;
      n_rst    = 1'b1;
      out_full = 1'b0;
      build_sbox();
      set_key('0);
      update_fifo();
      @(posedge clk);
      #1;
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
